// File: rtl/foo_feeder_pkg.sv
// Purpose : shared widths, response record and index clamp for the foo lookup feeder.
// Latency : n/a (types, constants and a pure function).
// Backpressure: n/a.
package foo_feeder_pkg;

  localparam int WORD_W      = 32;
  localparam int NUM_ENTRIES = 4;
  localparam int SEL_W       = $clog2(NUM_ENTRIES);
  localparam int PIPE_LAT    = 3;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [SEL_W-1:0]  idx;
  } resp_t;

  // Same clamp foo applies: widen sel by one bit, add one, saturate at the last entry.
  function automatic logic [SEL_W-1:0] clamp_idx(input logic [SEL_W-1:0] sel);
    logic [SEL_W:0] w_sum;
    w_sum = {1'b0, sel} + (SEL_W+1)'(1);
    if (w_sum > (SEL_W+1)'(NUM_ENTRIES-1)) begin
      return SEL_W'(NUM_ENTRIES-1);
    end
    return w_sum[SEL_W-1:0];
  endfunction

endpackage

// File: rtl/foo_resp_fifo.sv
// Purpose : synchronous FIFO of resp_t records; head is read from storage (no fall-through).
// Latency : a push into an empty FIFO is visible on o_vld the following cycle.
// Backpressure: o_vld/i_pop handshake on the read side; writer must hold a credit (overflow is asserted).
// Ports   : i_clk, i_rst (async, active high), i_push/i_push_dat write side,
//           i_pop/o_vld/o_head read side, o_count current occupancy.
module foo_resp_fifo
  import foo_feeder_pkg::*;
#(
  parameter int DEPTH = 5
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  resp_t                        i_push_dat,
  input  logic                         i_pop,
  output logic                         o_vld,
  output resp_t                        o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_t             r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= ptr_next(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_vld   = (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && (r_count == CNT_W'(DEPTH)) && !i_pop));

endmodule

// File: rtl/foo_lookup_feeder.sv
// Purpose : holds the lookup table for foo, tracks foo's latency, returns results in order.
// Latency : request accepted in cycle t -> response valid in cycle t+PIPE_LAT+1.
// Backpressure: credit-limited; req_ready drops once FIFO + in-flight reaches RESP_DEPTH.
// Ports   : i_clk/i_rst; i_wr_* table write; i_req_*/o_req_ready request; o_pipe_sel/o_pipe_arr
//           to foo, i_pipe_out from foo; o_resp_valid/i_resp_ready/o_resp_data/o_resp_idx response.
module foo_lookup_feeder
  import foo_feeder_pkg::*;
#(
  parameter int RESP_DEPTH = 5
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_wr_valid,
  input  logic [SEL_W-1:0]              i_wr_idx,
  input  logic [WORD_W-1:0]             i_wr_data,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic [SEL_W-1:0]              i_req_sel,
  output logic [SEL_W-1:0]              o_pipe_sel,
  output logic [NUM_ENTRIES*WORD_W-1:0] o_pipe_arr,
  input  logic [WORD_W-1:0]             i_pipe_out,
  output logic                          o_resp_valid,
  input  logic                          i_resp_ready,
  output logic [WORD_W-1:0]             o_resp_data,
  output logic [SEL_W-1:0]              o_resp_idx
);

  localparam int CNT_W = $clog2(RESP_DEPTH+1);

  logic [WORD_W-1:0]   r_tbl [NUM_ENTRIES];
  logic [PIPE_LAT-1:0] r_vld_sr;
  logic [SEL_W-1:0]    r_idx_sr [PIPE_LAT];
  logic                r_live;
  logic                w_fire;
  logic [CNT_W-1:0]    w_fifo_count;
  logic [CNT_W:0]      w_inflight;
  logic [CNT_W:0]      w_used;
  resp_t               w_push_dat;
  resp_t               w_head;

  assign w_fire     = i_req_valid && o_req_ready;
  assign o_pipe_sel = i_req_sel;

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_arr
    assign o_pipe_arr[g*WORD_W +: WORD_W] = r_tbl[g];
  end

  // Table updates at the edge; foo samples o_pipe_arr at that same edge, so a
  // same-cycle request sees the pre-write word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_tbl[i] <= '0;
      end
    end else if (i_wr_valid) begin
      r_tbl[i_wr_idx] <= i_wr_data;
    end
  end

  // Valid/index shadow of foo's pipeline; clearing it on reset drops in-flight
  // requests and makes foo's stale outputs invisible.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld_sr <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_idx_sr[i] <= '0;
      end
      r_live <= 1'b0;
    end else begin
      r_vld_sr    <= {r_vld_sr[PIPE_LAT-2:0], w_fire};
      r_idx_sr[0] <= clamp_idx(i_req_sel);
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_idx_sr[i] <= r_idx_sr[i-1];
      end
      r_live <= 1'b1;
    end
  end

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < PIPE_LAT; i++) begin
      w_inflight = w_inflight + {{CNT_W{1'b0}}, r_vld_sr[i]};
    end
  end

  // Credits come from registered state only: a pop this cycle frees its slot next cycle.
  assign w_used      = {1'b0, w_fifo_count} + w_inflight;
  assign o_req_ready = r_live && (w_used < (CNT_W+1)'(RESP_DEPTH));

  assign w_push_dat.word = i_pipe_out;
  assign w_push_dat.idx  = r_idx_sr[PIPE_LAT-1];

  foo_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (r_vld_sr[PIPE_LAT-1]),
    .i_push_dat (w_push_dat),
    .i_pop      (i_resp_ready),
    .o_vld      (o_resp_valid),
    .o_head     (w_head),
    .o_count    (w_fifo_count)
  );

  assign o_resp_data = w_head.word;
  assign o_resp_idx  = w_head.idx;

endmodule

// File: tb/tb_foo_lookup_feeder.sv
module tb_foo_lookup_feeder;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_valid;
  logic [1:0]   wr_idx;
  logic [31:0]  wr_data;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_sel;
  logic [1:0]   pipe_sel;
  logic [127:0] pipe_arr;
  logic [31:0]  pipe_out;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_data;
  logic [1:0]   resp_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_fire   = 0;

  typedef struct { logic [31:0] word; logic [1:0] idx; int cyc; } exp_t;
  typedef struct { logic [31:0] word; logic [1:0] idx; int cyc; int lat; } got_t;
  typedef struct {
    logic wr; logic [1:0] widx; logic [31:0] wdat;
    logic [1:0] sel; logic [31:0] exp_word; logic [1:0] exp_idx;
  } vec_t;

  exp_t        exp_q[$];
  got_t        got_q[$];
  logic [31:0] shadow [4];

  foo_lookup_feeder dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_valid(wr_valid), .i_wr_idx(wr_idx), .i_wr_data(wr_data),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_sel(req_sel),
    .o_pipe_sel(pipe_sel), .o_pipe_arr(pipe_arr), .i_pipe_out(pipe_out),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_data(resp_data), .o_resp_idx(resp_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int clamp_ref(input int s);
    return (s + 1 > 3) ? 3 : s + 1;
  endfunction

  // Behavioural stand-in for foo: three registers, no valid, no reset.
  logic [31:0] f1, f2, f3;
  always @(posedge clk) begin
    f1 <= pipe_arr[clamp_ref(int'(pipe_sel))*32 +: 32];
    f2 <= f1;
    f3 <= f2;
  end
  assign pipe_out = f3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level reference: each accepted request expects the table word
  // as it stood before any same-edge write; responses must come back in order.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 4; i++) shadow[i] = '0;
    end else begin
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          got_t g;
          e = exp_q.pop_front();
          check("sb_resp_data", resp_data, e.word);
          check("sb_resp_idx", {30'd0, resp_idx}, {30'd0, e.idx});
          g.word = resp_data; g.idx = resp_idx; g.cyc = cyc; g.lat = cyc - e.cyc;
          got_q.push_back(g);
        end
      end
      if (req_valid && req_ready) begin
        exp_t e;
        e.idx  = 2'(clamp_ref(int'(req_sel)));
        e.word = shadow[e.idx];
        e.cyc  = cyc;
        exp_q.push_back(e);
        n_fire++;
        check("credit_bound", {31'd0, exp_q.size() <= 5}, 32'd1);
      end
      if (wr_valid) shadow[wr_idx] = wr_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input string name, input int n, input int budget);
    while (got_q.size() < n && budget > 0) begin
      step();
      budget--;
    end
    check(name, got_q.size(), n);
  endtask

  task automatic wait_ready(input int budget);
    while (!req_ready && budget > 0) begin
      step();
      budget--;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic [31:0] t1_word [4];
    logic [1:0]  t1_idx  [4];
    logic        all_rdy;
    int          n0;

    rst = 1'b1; wr_valid = 0; wr_idx = 0; wr_data = 0;
    req_valid = 0; req_sel = 0; resp_ready = 0;

    // Reset state
    step(); step();
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_idx", {30'd0, resp_idx}, 32'd0);
    rst = 1'b0;
    step();
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // 1) table {D,C,B,A}, sel 0..3 back-to-back
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1; wr_idx = 2'(i); wr_data = 32'hA + i;
      step();
    end
    wr_valid = 0;
    resp_ready = 1;
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1; req_sel = 2'(i);
      step();
    end
    req_valid = 0;
    wait_resp("t1_count", 4, 40);
    t1_word = '{32'hB, 32'hC, 32'hD, 32'hD};
    t1_idx  = '{2'd1, 2'd2, 2'd3, 2'd3};
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      check("t1_word", got_q[i].word, t1_word[i]);
      check("t1_idx", {30'd0, got_q[i].idx}, {30'd0, t1_idx[i]});
    end
    if (got_q.size() > 0) check("t1_first_latency", got_q[0].lat, 32'd4);

    // 2) credit limit with the consumer stalled
    step();
    resp_ready = 0;
    n_fire = 0;
    got_q.delete();
    for (int i = 0; i < 10; i++) begin
      req_valid = 1; req_sel = 2'($urandom_range(0, 3));
      step();
    end
    req_valid = 0;
    check("t2_accepted", n_fire, 32'd5);
    check("t2_ready_low", {31'd0, req_ready}, 32'd0);
    resp_ready = 1;
    wait_resp("t2_drain", 5, 40);
    step();
    check("t2_ready_back", {31'd0, req_ready}, 32'd1);
    n0 = n_fire;
    req_valid = 1; req_sel = 2'd0;
    step();
    req_valid = 0;
    check("t2_resume", n_fire, n0 + 1);
    wait_resp("t2_resume_resp", 6, 20);

    // 3) same-cycle write vs request, table-driven (table is {D,C,B,A})
    vecs[0] = '{1'b1, 2'd2, 32'h55, 2'd1, 32'hC,  2'd2};
    vecs[1] = '{1'b0, 2'd0, 32'h0,  2'd1, 32'h55, 2'd2};
    vecs[2] = '{1'b1, 2'd3, 32'h77, 2'd3, 32'hD,  2'd3};
    vecs[3] = '{1'b0, 2'd0, 32'h0,  2'd2, 32'h77, 2'd3};
    vecs[4] = '{1'b1, 2'd1, 32'h11, 2'd0, 32'hB,  2'd1};
    vecs[5] = '{1'b0, 2'd0, 32'h0,  2'd0, 32'h11, 2'd1};
    for (int v = 0; v < 6; v++) begin
      wait_ready(20);
      got_q.delete();
      wr_valid = vecs[v].wr; wr_idx = vecs[v].widx; wr_data = vecs[v].wdat;
      req_valid = 1; req_sel = vecs[v].sel;
      step();
      wr_valid = 0; req_valid = 0;
      wait_resp("t3_wait", 1, 20);
      if (got_q.size() > 0) begin
        check("t3_word", got_q[0].word, vecs[v].exp_word);
        check("t3_idx", {30'd0, got_q[0].idx}, {30'd0, vecs[v].exp_idx});
      end
    end

    // 4) sustained throughput
    got_q.delete();
    all_rdy = 1;
    for (int i = 0; i < 20; i++) begin
      req_valid = 1; req_sel = 2'($urandom_range(0, 3));
      if (!req_ready) all_rdy = 0;
      step();
    end
    req_valid = 0;
    check("t4_ready_held", {31'd0, all_rdy}, 32'd1);
    wait_resp("t4_count", 20, 40);
    if (got_q.size() == 20) check("t4_back_to_back", got_q[19].cyc - got_q[0].cyc, 32'd19);

    // 5) reset with three requests in flight
    step();
    for (int i = 0; i < 3; i++) begin
      req_valid = 1; req_sel = 2'(i);
      step();
    end
    req_valid = 0;
    rst = 1;
    #1;
    check("t5_ready_in_rst", {31'd0, req_ready}, 32'd0);
    step();
    check("t5_ready_in_rst2", {31'd0, req_ready}, 32'd0);
    step();
    got_q.delete();
    rst = 0;
    for (int i = 0; i < 8; i++) step();
    check("t5_no_stale_resp", got_q.size(), 32'd0);
    check("t5_resp_valid_low", {31'd0, resp_valid}, 32'd0);
    req_valid = 1; req_sel = 2'd2;
    step();
    req_valid = 0;
    wait_resp("t5_post_rst", 1, 20);
    if (got_q.size() > 0) begin
      check("t5_table_zero", got_q[0].word, 32'd0);
      check("t5_idx", {30'd0, got_q[0].idx}, 32'd3);
    end

    // 6) random traffic against the reference
    for (int i = 0; i < 10000; i++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_sel    = 2'($urandom_range(0, 3));
      wr_valid   = ($urandom_range(0, 3) == 0);
      wr_idx     = 2'($urandom_range(0, 3));
      wr_data    = $urandom;
      resp_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    req_valid = 0; wr_valid = 0; resp_ready = 1;
    for (int i = 0; i < 50 && (exp_q.size() != 0 || resp_valid); i++) step();
    check("t6_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
